mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage ARM pipeline, including the MEM/WB pipeline register. It consumes the EXE/MEM register outputs (`wb_en`, `mem_read_en`, `mem_write_en`, `alu_res`, `val_Rm`, `dest`) and performs loads and stores against an internal multi-cycle data memory. While an access is in flight it asserts `freeze` to stall every upstream stage, and it presents registered results to the write-back stage.

## Interface
Parameters:
- `DEPTH`, 64: data memory size in 32-bit words.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `LATENCY`, 2: memory wait cycles per access; legal range ≥1.

Ports (`clk` single clock; `rst` asynchronous, active-low):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `wb_en_in`  in  1  write-back enable from the EXE/MEM register.
- `mem_read_en_in`  in  1  load request.
- `mem_write_en_in`  in  1  store request.
- `alu_res_in`  in  32  effective byte address, or the ALU result for non-memory instructions.
- `val_Rm_in`  in  32  store data.
- `dest_in`  in  4  destination register.
- `freeze`  out  1  stall for the PC, IF/ID, ID/EX and EXE/MEM registers.
- `wb_en`  out  1  registered write-back enable.
- `mem_read_en`  out  1  registered write-back mux select.
- `alu_res`  out  32  registered ALU result.
- `mem_data`  out  32  registered load data.
- `dest`  out  4  registered destination register.

## Operation
- FSM states:
  - IDLE: a request (`mem_read_en_in | mem_write_en_in`) → WAIT, counter loaded with LATENCY−1. No request → stay in IDLE.
  - WAIT: counter decrements each cycle. At counter 0 → DONE. The memory commits a store, or samples load data, on the WAIT→DONE edge.
  - DONE: → IDLE unconditionally. Inputs are ignored for new-request detection in this state.
- `freeze` is combinational: (IDLE & request) | WAIT. It is 0 in DONE.
- MEM/WB register capture rules:
  - IDLE without a request, or DONE: capture `wb_en`, `mem_read_en`, `alu_res`, `dest` from the inputs. Capture `mem_data` from the load data, or 0 if the instruction is not a load.
  - While `freeze` = 1: insert a bubble. `wb_en` ← 0 and `mem_read_en` ← 0; other fields hold.
- Address: index = (`alu_res_in` − BASE_ADDR) >> 2, using 32-bit unsigned subtraction. Low 2 bits are ignored.
- Out of range (index ≥ DEPTH, including underflow): a store is dropped and a load returns 0.
- Read and write both asserted: treated as a store; `mem_data` = 0.
- The memory array is not reset.

## Timing
- Reset values: state = IDLE; `freeze` = 0; `wb_en` = 0; `mem_read_en` = 0; `alu_res` = 0; `mem_data` = 0; `dest` = 0.
- Non-memory instruction: one cycle, no freeze. The MEM/WB register updates on the next edge.
- Memory instruction arriving in cycle c:
  - `freeze` is high in cycles c through c+LATENCY.
  - DONE occurs in cycle c+LATENCY+1; the MEM/WB register updates at the end of that cycle.
  - Total occupancy is LATENCY+2 cycles, with LATENCY+1 bubbles emitted.
- Upstream holds the EXE/MEM register while `freeze` = 1, so the inputs are stable from c through DONE.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE. There is no overlap.
- Reset asserted mid-access: immediate return to IDLE and `freeze` = 0. A store not yet committed is lost; a store already committed persists.

## Structure
- Package `mem_stage_pkg` holds:
  - the state enum (IDLE/WAIT/DONE);
  - the counter width, $clog2(LATENCY)+1;
  - a function `addr_to_index` implementing the address rule and range check.
- Sub-module `data_memory`: a synchronous word array with write enable, read enable and an in-range flag. The FSM, counter, freeze logic and MEM/WB register stay in `mem_stage`.

## Test plan
- Reset: drive `rst` = 0 with inputs active → all outputs 0, `freeze` = 0.
- ALU pass-through: `wb_en_in` = 1, `alu_res_in` = 0x55, `dest_in` = 3, no memory request → next edge gives `wb_en` = 1, `alu_res` = 0x55, `dest` = 3, with `freeze` never high.
- Store then load (LATENCY = 2):
  - Store 0xDEADBEEF at 1032 → `freeze` high 3 cycles, `wb_en` = 0 for those 3 edges.
  - Load from 1032 → `mem_data` = 0xDEADBEEF, `mem_read_en` = 1, exactly one `wb_en` pulse.
- Out of range: store to 1020 and 1024 + 4·DEPTH → memory unchanged; load from either returns 0.
- Reset mid-WAIT: assert `rst` one cycle into a store to 1028 → `freeze` drops immediately; a later load from 1028 returns the prior contents.
- Back-to-back loads from 1024 and 1028 → two DONE cycles separated by LATENCY+1 freeze cycles, results in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage: FSM state encoding,
// access-counter sizing and the byte-address to word-index mapping.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // Result of mapping a byte address onto the data memory.
    typedef struct packed {
        logic        in_range;
        logic [31:0] index;
    } mem_index_t;

    // Counter must hold LATENCY-1 and still have room for the zero test.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return $clog2(latency) + 1;
    endfunction

    // Word index is (addr - base) >> 2 with 32-bit unsigned wrap, so an
    // address below the base underflows into a huge index and falls out of range.
    function automatic mem_index_t addr_to_index(input logic [31:0]  addr,
                                                 input logic [31:0]  base,
                                                 input int unsigned  depth);
        mem_index_t  r;
        logic [31:0] off;
        off        = addr - base;
        r.index    = off >> 2;
        r.in_range = (r.index < depth);
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Synchronous word-addressed data memory. Writes and reads take effect on the
// clock edge when enabled; out-of-range accesses drop the store and read zero.
// The array itself is never reset.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        we,
    input  logic        re,
    input  logic        in_range,
    input  logic [31:0] idx,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [DEPTH];

    // Store commit: only the addressed word, and only when the index is valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (we && in_range && (idx == i)) begin
                mem[i] <= wdata;
            end
        end
    end

    // Load sample: zero unless the index selects a real word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (in_range && (idx == i)) begin
                    rdata <= mem[i];
                end
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage ARM pipeline with the MEM/WB register. Memory
// requests walk IDLE -> WAIT (LATENCY cycles) -> DONE while freeze stalls the
// upstream stages; the MEM/WB register emits bubbles until the access completes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  dest_in,
    output logic        freeze,
    output logic        wb_en,
    output logic        mem_read_en,
    output logic [31:0] alu_res,
    output logic [31:0] mem_data,
    output logic [3:0]  dest
);

    localparam int unsigned      CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    mem_index_t       ai;
    logic             req;
    logic             is_load;
    logic             access_edge;
    logic [31:0]      rd_data;

    // Request decode and address mapping; read+write together counts as a store.
    always_comb begin
        ai          = addr_to_index(alu_res_in, BASE_ADDR, DEPTH);
        req         = mem_read_en_in | mem_write_en_in;
        is_load     = mem_read_en_in & ~mem_write_en_in;
        access_edge = (state == WAIT) && (cnt == '0);
    end

    // Stall upstream while a request is accepted or in flight. Gated by the
    // async reset so freeze drops the instant reset asserts.
    always_comb begin
        freeze = rst && (((state == IDLE) && req) || (state == WAIT));
    end

    // Access sequencer: load LATENCY-1, count down in WAIT, one DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    data_memory #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk      (clk),
        .we       (access_edge & mem_write_en_in),
        .re       (access_edge & is_load),
        .in_range (ai.in_range),
        .idx      (ai.index),
        .wdata    (val_Rm_in),
        .rdata    (rd_data)
    );

    // MEM/WB register: bubble while frozen, otherwise capture the instruction.
    // Load data is only meaningful in DONE; outside it is_load is 0 anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en       <= 1'b0;
            mem_read_en <= 1'b0;
            alu_res     <= '0;
            mem_data    <= '0;
            dest        <= '0;
        end else if (freeze) begin
            wb_en       <= 1'b0;
            mem_read_en <= 1'b0;
        end else begin
            wb_en       <= wb_en_in;
            mem_read_en <= mem_read_en_in;
            alu_res     <= alu_res_in;
            dest        <= dest_in;
            mem_data    <= ((state == DONE) && is_load) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a transaction-level model predicts the
// freeze level and MEM/WB contents of every cycle; directed cases pin the
// model with hand-computed values, then randomized instructions follow.
module tb_mem_stage;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en_in = 1'b0;
    logic        mem_read_en_in = 1'b0;
    logic        mem_write_en_in = 1'b0;
    logic [31:0] alu_res_in = '0;
    logic [31:0] val_Rm_in = '0;
    logic [3:0]  dest_in = '0;
    logic        freeze;
    logic        wb_en;
    logic        mem_read_en;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [3:0]  dest;

    mem_stage #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_en_in        (wb_en_in),
        .mem_read_en_in  (mem_read_en_in),
        .mem_write_en_in (mem_write_en_in),
        .alu_res_in      (alu_res_in),
        .val_Rm_in       (val_Rm_in),
        .dest_in         (dest_in),
        .freeze          (freeze),
        .wb_en           (wb_en),
        .mem_read_en     (mem_read_en),
        .alu_res         (alu_res),
        .mem_data        (mem_data),
        .dest            (dest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb;
        logic        rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic [3:0]  dst;
    } out_t;

    typedef struct packed {
        logic frz;
        out_t out;
    } cyc_t;

    cyc_t        exp_q[$];
    cyc_t        e_cur;
    out_t        cur_out = '0;
    out_t        m_out = '0;
    logic [31:0] mdl_mem [DEPTH];
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] d = a - BASE;
        return (d >> 2) < DEPTH;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] d = a - BASE;
        return d >> 2;
    endfunction

    // Per-cycle compare: freeze of this cycle, and outputs captured at the previous edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow at %0t: got empty queue expected an entry", $time);
            end else begin
                e_cur = exp_q.pop_front();
                chk("freeze", {31'd0, freeze}, {31'd0, e_cur.frz});
                chk("wb_en", {31'd0, wb_en}, {31'd0, cur_out.wb});
                chk("mem_read_en", {31'd0, mem_read_en}, {31'd0, cur_out.rd});
                chk("alu_res", alu_res, cur_out.alu);
                chk("mem_data", mem_data, cur_out.data);
                chk("dest", {28'd0, dest}, {28'd0, cur_out.dst});
                cur_out = e_cur.out;
            end
        end
    end

    // Present one instruction, held for as long as the stage occupies it
    // (1 cycle, or LAT+2 for a memory access), and queue the expected cycles.
    // Entered and left just after a rising edge.
    task automatic run_instr(input logic wb, input logic rd, input logic wr,
                             input logic [31:0] alu, input logic [31:0] val,
                             input logic [3:0] dst, output int frz_n, output int wb_n);
        bit          mem_op = rd | wr;
        int unsigned n = mem_op ? LAT + 2 : 1;
        logic [31:0] ld = '0;
        cyc_t        e;
        frz_n = 0;
        wb_n  = 0;
        if (rd && !wr && in_rng(alu)) ld = mdl_mem[widx(alu)];
        if (wr && in_rng(alu)) mdl_mem[widx(alu)] = val;
        for (int unsigned i = 0; i < n; i++) begin
            wb_en_in        = wb;
            mem_read_en_in  = rd;
            mem_write_en_in = wr;
            alu_res_in      = alu;
            val_Rm_in       = val;
            dest_in         = dst;
            e.frz = mem_op && (i != n - 1);
            if (e.frz) begin
                m_out.wb = 1'b0;
                m_out.rd = 1'b0;
            end else begin
                m_out = '{wb, rd, alu, ld, dst};
            end
            e.out = m_out;
            exp_q.push_back(e);
            @(negedge clk);
            if (freeze === 1'b1) frz_n++;
            @(posedge clk);
            #1;
            if (wb_en === 1'b1) wb_n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          fz;
        int          wp;
        logic [31:0] prior;
        logic [31:0] a;
        int unsigned kind;

        // Reset with every input active.
        rst = 1'b0;
        wb_en_in = 1'b1; mem_read_en_in = 1'b1; mem_write_en_in = 1'b1;
        alu_res_in = 32'h0000_0408; val_Rm_in = 32'h1234_5678; dest_in = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_mem_read_en", {31'd0, mem_read_en}, 32'd0);
        chk("rst_alu_res", alu_res, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_dest", {28'd0, dest}, 32'd0);
        rst = 1'b1;
        cur_out = '0;
        m_out = '0;
        chk_en = 1'b1;

        // ALU pass-through.
        run_instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, fz, wp);
        chk("alu_pass_wb_en", {31'd0, wb_en}, 32'd1);
        chk("alu_pass_alu_res", alu_res, 32'h55);
        chk("alu_pass_dest", {28'd0, dest}, 32'd3);
        chk("alu_pass_freeze_cycles", fz, 32'd0);

        // Fill memory so every word has a known value.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            run_instr(1'b0, 1'b0, 1'b1, BASE + 4 * i, $urandom, 4'd0, fz, wp);
        end

        // Store then load at 1032.
        run_instr(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0, fz, wp);
        chk("store_freeze_cycles", fz, 32'd3);
        chk("store_wb_pulses", wp, 32'd0);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, fz, wp);
        chk("load_data", mem_data, 32'hDEADBEEF);
        chk("load_mem_read_en", {31'd0, mem_read_en}, 32'd1);
        chk("load_wb_pulses", wp, 32'd1);
        chk("load_freeze_cycles", fz, 32'd3);

        // Out-of-range stores and loads on both sides of the window.
        run_instr(1'b0, 1'b0, 1'b1, 32'd1020, $urandom, 4'd0, fz, wp);
        run_instr(1'b0, 1'b0, 1'b1, BASE + 4 * DEPTH, $urandom, 4'd0, fz, wp);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd1, fz, wp);
        chk("oor_low_load", mem_data, 32'd0);
        run_instr(1'b1, 1'b1, 1'b0, BASE + 4 * DEPTH, 32'h0, 4'd2, fz, wp);
        chk("oor_high_load", mem_data, 32'd0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            run_instr(1'b1, 1'b1, 1'b0, BASE + 4 * i, 32'h0, 4'(i), fz, wp);
        end

        // Reset one cycle into a store to 1028: the store must be lost.
        chk_en = 1'b0;
        prior = mdl_mem[1];
        wb_en_in = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b1;
        alu_res_in = 32'd1028; val_Rm_in = ~prior; dest_in = 4'd0;
        @(negedge clk);
        chk("rstw_freeze_idle", {31'd0, freeze}, 32'd1);
        @(posedge clk);
        #1;
        chk("rstw_freeze_wait", {31'd0, freeze}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw_freeze_drop", {31'd0, freeze}, 32'd0);
        chk("rstw_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rstw_alu_res", alu_res, 32'd0);
        mem_write_en_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur_out = '0;
        m_out = '0;
        chk_en = 1'b1;
        run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5, fz, wp);
        chk("rstw_keep", mem_data, prior);

        // Back-to-back loads.
        run_instr(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd8, fz, wp);
        chk("b2b_first", mem_data, mdl_mem[0]);
        chk("b2b_first_freeze", fz, 32'd3);
        run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd9, fz, wp);
        chk("b2b_second", mem_data, mdl_mem[1]);
        chk("b2b_second_freeze", fz, 32'd3);

        // Randomized instruction mix.
        for (int unsigned n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE - 32'($urandom_range(1, 8));
                2:       a = BASE + 4 * DEPTH + 32'($urandom_range(0, 7));
                default: a = BASE + 4 * $urandom_range(0, DEPTH - 1) + 32'($urandom_range(0, 3));
            endcase
            run_instr(1'($urandom_range(0, 1)), kind[0], kind[1], a, $urandom,
                      4'($urandom_range(0, 15)), fz, wp);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
